// File: rtl/fprint_onchip_ram_dp.sv
// Dual-port on-chip word RAM with byte lanes, pipelined reads, a global stall
// and a post-reset zero-fill engine.
module fprint_onchip_ram_dp #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 18,
  parameter int unsigned DEPTH          = 153600,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = "fprint_onchip_ram_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    busy,
  output logic                    collision
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Elaboration-time parameter sanity; preload from INIT_FILE belongs to the memory flow.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH == 0 || $clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH must be 1..2**ADDR_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (!CLEAR_ON_RESET && INIT_FILE == "") begin : g_bad_init
    $error("CLEAR_ON_RESET=0 needs an INIT_FILE");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic                    w_clr_we;
  logic                    w_en, w_wait, w_coll;
  logic                    r_collision;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_addr  [2];
  logic [MEM_AW-1:0]       w_idx   [2];
  logic [BE_W-1:0]         w_be    [2];
  logic [DATA_WIDTH-1:0]   w_wdata [2];
  logic [DATA_WIDTH-1:0]   w_rdata [2];
  logic [1:0]              w_cs, w_rd, w_wr, w_inr, w_acc, w_wr_ok, w_do_wr, w_do_rd;

  assign w_addr[0]  = s1_address;    assign w_addr[1]  = s2_address;
  assign w_be[0]    = s1_byteenable; assign w_be[1]    = s2_byteenable;
  assign w_wdata[0] = s1_writedata;  assign w_wdata[1] = s2_writedata;
  assign w_cs = {s2_chipselect, s1_chipselect};
  assign w_rd = {s2_read, s1_read};
  assign w_wr = {s2_write, s1_write};

  assign w_en   = clken & ~reset_req;
  assign busy   = (r_state == S_CLEAR);
  assign w_wait = busy | ~w_en | reset;
  assign s1_waitrequest = w_wait;
  assign s2_waitrequest = w_wait;

  // Same-address dual write: s1 wins outright, s2 is dropped.
  assign w_coll     = w_wr_ok[0] & w_wr_ok[1] & (w_addr[0] == w_addr[1]);
  assign w_do_wr[0] = w_wr_ok[0];
  assign w_do_wr[1] = w_wr_ok[1] & ~w_coll;
  assign collision  = r_collision;

  for (genvar p = 0; p < 2; p++) begin : g_cmd
    assign w_inr[p]   = {1'b0, w_addr[p]} < (ADDR_WIDTH+1)'(DEPTH);
    assign w_idx[p]   = w_addr[p][MEM_AW-1:0];
    assign w_acc[p]   = w_cs[p] & (w_rd[p] | w_wr[p]) & ~w_wait;
    assign w_wr_ok[p] = w_acc[p] & w_wr[p] & w_inr[p];
    assign w_do_rd[p] = w_acc[p] & w_rd[p] & ~w_wr[p];
    assign w_rdata[p] = w_inr[p] ? r_mem[w_idx[p]] : '0;
  end

  // Clear engine: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_cnt       <= '0;
      r_collision <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_collision <= w_coll;
    end
  end

  // Clear engine: one zero word per enabled cycle, stops on DEPTH-1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (w_en && !reset) begin
          w_clr_we = 1'b1;
          if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = S_IDLE;
          else                                 w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Array writes; port writes are impossible while clearing (waitrequest high)
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_cnt[MEM_AW-1:0]] <= '0;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (w_do_wr[1] && w_be[1][b]) r_mem[w_idx[1]][b*8 +: 8] <= w_wdata[1][b*8 +: 8];
      if (w_do_wr[0] && w_be[0][b]) r_mem[w_idx[0]][b*8 +: 8] <= w_wdata[0][b*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  w_v_in;
    logic [DATA_WIDTH-1:0] w_d_in;
    logic                  r_v_o;
    logic [DATA_WIDTH-1:0] r_d_o;

    if (READ_LATENCY == 2) begin : g_l2
      logic                  r_v_a;
      logic [DATA_WIDTH-1:0] r_d_a;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_v_a <= 1'b0;
          r_d_a <= '0;
        end else if (w_en) begin
          r_v_a <= w_do_rd[p];
          if (w_do_rd[p]) r_d_a <= w_rdata[p];
        end
      end
      assign w_v_in = r_v_a;
      assign w_d_in = r_d_a;
    end else begin : g_l1
      assign w_v_in = w_do_rd[p];
      assign w_d_in = w_rdata[p];
    end

    // Output stage freezes with the rest of the pipe while disabled
    always_ff @(posedge clk) begin
      if (reset) begin
        r_v_o <= 1'b0;
        r_d_o <= '0;
      end else if (w_en) begin
        r_v_o <= w_v_in;
        if (w_v_in) r_d_o <= w_d_in;
      end
    end
  end

  assign s1_readdata      = g_port[0].r_d_o;
  assign s1_readdatavalid = g_port[0].r_v_o;
  assign s2_readdata      = g_port[1].r_d_o;
  assign s2_readdatavalid = g_port[1].r_v_o;

endmodule

// File: tb/tb_fprint_onchip_ram_dp.sv
// Directed bench for fprint_onchip_ram_dp: DEPTH=16, 32-bit words, 2-cycle reads.
module tb_fprint_onchip_ram_dp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, reset_req, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
  logic          busy, collision;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  fprint_onchip_ram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b1), .INIT_FILE("fprint_onchip_ram_dp.hex")
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .busy(busy), .collision(collision)
  );

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 read+write
    int          port;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_ports();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (p == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = be;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_writedata = d; s2_byteenable = be;
    end
  endtask

  function automatic logic [31:0] f_rdata(input int p);
    return (p == 1) ? s1_readdata : s2_readdata;
  endfunction
  function automatic logic f_valid(input int p);
    return (p == 1) ? s1_readdatavalid : s2_readdatavalid;
  endfunction
  function automatic logic f_wait(input int p);
    return (p == 1) ? s1_waitrequest : s2_waitrequest;
  endfunction

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, input string name);
    chk({name, "_wreq"}, 32'(f_wait(p)), 32'd0);
    drive(p, 1'b0, 1'b1, a, d, be);
    step();
    idle_ports();
  endtask

  // Read with exact 2-cycle latency and single-cycle valid pulse
  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [31:0] exp,
                         input string name);
    chk({name, "_wreq"}, 32'(f_wait(p)), 32'd0);
    drive(p, 1'b1, 1'b0, a, '0, '0);
    step();
    idle_ports();
    chk({name, "_early"}, 32'(f_valid(p)), 32'd0);
    step();
    chk({name, "_valid"}, 32'(f_valid(p)), 32'd1);
    chk({name, "_data"}, f_rdata(p), exp);
    step();
    chk({name, "_pulse"}, 32'(f_valid(p)), 32'd0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      chk("clear_wreq", 32'(s1_waitrequest & s2_waitrequest), 32'd1);
      n++;
      step();
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rd1"}, s1_readdata, 32'd0);
    chk({name, "_rd2"}, s2_readdata, 32'd0);
    chk({name, "_vld"}, 32'({s2_readdatavalid, s1_readdatavalid}), 32'd0);
    chk({name, "_coll"}, 32'(collision), 32'd0);
    chk({name, "_wreq"}, 32'({s2_waitrequest, s1_waitrequest}), 32'd3);
    chk({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int nb;
    vec_t v;
    reset = 1; reset_req = 0; clken = 1;
    idle_ports();

    // Power-up reset and full clear
    @(negedge clk);
    step(); step();
    chk_reset_outputs("rst");
    reset = 0;
    count_busy(nb);
    chk("clear_len", 32'(nb), 32'd16);

    vecs.push_back('{0, 1, 5'd3,  32'hAABBCCDD, 4'hF, 32'h0});
    vecs.push_back('{0, 1, 5'd3,  32'h11223344, 4'h5, 32'h0});
    vecs.push_back('{1, 2, 5'd3,  32'h0,        4'h0, 32'hAA22CC44});
    vecs.push_back('{1, 1, 5'd0,  32'h0,        4'h0, 32'h00000000});
    vecs.push_back('{0, 2, 5'd16, 32'hDEADBEEF, 4'hF, 32'h0});
    vecs.push_back('{1, 1, 5'd16, 32'h0,        4'h0, 32'h00000000});
    vecs.push_back('{1, 2, 5'd31, 32'h0,        4'h0, 32'h00000000});
    vecs.push_back('{0, 2, 5'd15, 32'h12345678, 4'hF, 32'h0});
    vecs.push_back('{1, 1, 5'd15, 32'h0,        4'h0, 32'h12345678});
    vecs.push_back('{0, 2, 5'd0,  32'hCAFEF00D, 4'hA, 32'h0});
    vecs.push_back('{1, 1, 5'd0,  32'h0,        4'h0, 32'hCA00F000});
    vecs.push_back('{0, 1, 5'd1,  32'h01010101, 4'hF, 32'h0});
    vecs.push_back('{0, 2, 5'd2,  32'h02020202, 4'hF, 32'h0});
    vecs.push_back('{2, 1, 5'd7,  32'h55555555, 4'hF, 32'h0});
    vecs.push_back('{1, 2, 5'd7,  32'h0,        4'h0, 32'h55555555});

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.kind == 0) begin
        do_write(v.port, v.addr, v.data, v.be, $sformatf("v%0d", i));
      end else if (v.kind == 1) begin
        do_read(v.port, v.addr, v.exp, $sformatf("v%0d", i));
      end else begin
        drive(v.port, 1'b1, 1'b1, v.addr, v.data, v.be);
        step();
        idle_ports();
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("v%0d_novalid%0d", i, k), 32'(f_valid(v.port)), 32'd0);
          step();
        end
      end
    end

    // Back-to-back reads: one result per cycle, in order
    drive(1, 1'b1, 1'b0, 5'd0, '0, '0); step();
    chk("bb_c1_vld", 32'(s1_readdatavalid), 32'd0);
    drive(1, 1'b1, 1'b0, 5'd1, '0, '0); step();
    chk("bb_c2_vld", 32'(s1_readdatavalid), 32'd1);
    chk("bb_c2_dat", s1_readdata, 32'hCA00F000);
    drive(1, 1'b1, 1'b0, 5'd2, '0, '0); step();
    idle_ports();
    chk("bb_c3_vld", 32'(s1_readdatavalid), 32'd1);
    chk("bb_c3_dat", s1_readdata, 32'h01010101);
    step();
    chk("bb_c4_vld", 32'(s1_readdatavalid), 32'd1);
    chk("bb_c4_dat", s1_readdata, 32'h02020202);
    step();
    chk("bb_c5_vld", 32'(s1_readdatavalid), 32'd0);

    // Stall with a read in flight, then a second read
    drive(1, 1'b1, 1'b0, 5'd3, '0, '0); step();
    idle_ports();
    reset_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_wreq", k), 32'({s2_waitrequest, s1_waitrequest}), 32'd3);
      chk($sformatf("stall%0d_vld", k), 32'(s1_readdatavalid), 32'd0);
      step();
    end
    reset_req = 0;
    chk("stall_end_vld", 32'(s1_readdatavalid), 32'd0);
    drive(1, 1'b1, 1'b0, 5'd15, '0, '0); step();
    idle_ports();
    chk("stall_a_vld", 32'(s1_readdatavalid), 32'd1);
    chk("stall_a_dat", s1_readdata, 32'hAA22CC44);
    step();
    chk("stall_b_vld", 32'(s1_readdatavalid), 32'd1);
    chk("stall_b_dat", s1_readdata, 32'h12345678);
    step();
    chk("stall_done_vld", 32'(s1_readdatavalid), 32'd0);

    clken = 0; #1;
    chk("clken_wreq", 32'({s2_waitrequest, s1_waitrequest}), 32'd3);
    clken = 1; #1;
    chk("clken_wreq_off", 32'({s2_waitrequest, s1_waitrequest}), 32'd0);

    // Same-address dual write
    chk("coll_pre", 32'(collision), 32'd0);
    drive(1, 1'b0, 1'b1, 5'd5, 32'h1, 4'hF);
    drive(2, 1'b0, 1'b1, 5'd5, 32'h2, 4'hF);
    step();
    idle_ports();
    chk("coll_pulse", 32'(collision), 32'd1);
    step();
    chk("coll_after", 32'(collision), 32'd0);
    do_read(2, 5'd5, 32'h1, "coll_rd");

    // Read-during-write across ports returns old data
    drive(1, 1'b0, 1'b1, 5'd5, 32'h99, 4'hF);
    drive(2, 1'b1, 1'b0, 5'd5, '0, '0);
    step();
    idle_ports();
    chk("rdw_early", 32'(s2_readdatavalid), 32'd0);
    step();
    chk("rdw_vld", 32'(s2_readdatavalid), 32'd1);
    chk("rdw_dat", s2_readdata, 32'h1);
    step();
    do_read(1, 5'd5, 32'h99, "rdw_new");

    // Reset mid-read cancels it; reset at clear count 7 restarts the clear
    drive(1, 1'b1, 1'b0, 5'd3, '0, '0); step();
    idle_ports();
    reset = 1; step();
    chk_reset_outputs("rst2");
    reset = 0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("part%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("part%0d_vld", k), 32'(s1_readdatavalid), 32'd0);
      step();
    end
    reset = 1; step();
    reset = 0;
    count_busy(nb);
    chk("reclear_len", 32'(nb), 32'd16);
    for (int i = 0; i < int'(DEPTH); i++)
      do_read((i % 2) + 1, AW'(i), 32'h0, $sformatf("clr%0d", i));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fprint_onchip_ram_dp.md
FPRINT_ONCHIP_RAM_DP -- requirements
Module: fprint_onchip_ram_dp

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- DATA_WIDTH, 32, word width; multiple of 8.
- ADDR_WIDTH, 18, word address width.
- DEPTH, 153600, words implemented; DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, accepted read to readdatavalid, in cycles; legal values are 1 and 2.
- CLEAR_ON_RESET, 1, zero-fill the array after reset.
- INIT_FILE, "fprint_onchip_ram_dp.hex", contents at configuration; used when CLEAR_ON_RESET=0.

REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- reset_req, in, 1, memory-protect request; stalls both ports.
- clken, in, 1, global clock enable.
- sN_address, in, ADDR_WIDTH, word address; N = 1, 2.
- sN_chipselect, in, 1, port select.
- sN_read, in, 1, read strobe.
- sN_write, in, 1, write strobe.
- sN_byteenable, in, DATA_WIDTH/8, byte lanes.
- sN_writedata, in, DATA_WIDTH, write data.
- sN_readdata, out, DATA_WIDTH, read data.
- sN_readdatavalid, out, 1, read data valid.
- sN_waitrequest, out, 1, command not accepted.
- busy, out, 1, clear engine running.
- collision, out, 1, one-cycle pulse on a same-address dual write.

Function
REQ-003 The module SHALL use one clock, clk; reset is synchronous and active-high.
REQ-004 Enable: en = clken & ~reset_req.
REQ-005 sN_waitrequest SHALL equal busy | ~en | reset.
REQ-006 A command is accepted when sN_chipselect & (sN_read | sN_write) & ~sN_waitrequest.
REQ-007 Accepted write: only lanes with byteenable=1 update; other lanes keep their value.
REQ-008 Accepted read: readdata is presented with readdatavalid=1 exactly READ_LATENCY cycles later, as a one-cycle pulse.
REQ-009 Back-to-back reads on a port SHALL sustain one result per cycle, in order.
REQ-010 Read and write asserted together on a port: the write executes, no read is performed, and no readdatavalid follows.
REQ-011 When en=0, pipeline stages holding a read SHALL freeze: readdata/readdatavalid hold and resume when en=1. No result is lost or duplicated.
REQ-012 Address >= DEPTH: a write is dropped; a read returns all-zero data with normal readdatavalid timing.
REQ-013 Read-during-write, same address, same or opposite port: the read returns the old data.
REQ-014 Both ports write the same address in one cycle: s1 data wins on all lanes, s2 write is discarded, and collision=1 for that cycle.
REQ-015 Clear FSM states: IDLE, CLEAR.
- reset=1 forces CLEAR when CLEAR_ON_RESET=1, else IDLE; the counter is set to 0.
- In CLEAR, one word is written with zeros per cycle while en=1. The counter does not advance while en=0.
- When the counter reaches DEPTH-1 and that word is written, the FSM returns to IDLE.
- busy=1 in CLEAR only.
REQ-016 Counter width is ADDR_WIDTH. The counter never exceeds DEPTH-1 and does not wrap.
REQ-017 Reset asserted mid-clear restarts the clear at address 0. Reset asserted mid-read cancels all pending readdatavalid.

Reset
REQ-018 While reset=1, outputs SHALL be:
- sN_readdata = 0, sN_readdatavalid = 0, collision = 0.
- sN_waitrequest = 1.
- busy = 1 if CLEAR_ON_RESET=1, else 0.
REQ-019 After reset deassertion with CLEAR_ON_RESET=1, busy SHALL stay 1 for exactly DEPTH enabled cycles, then go to 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios (DEPTH=16, DATA_WIDTH=32 unless stated):
- Clear: reset for 2 cycles, then release -> busy=1 for 16 cycles; every address then reads 0x00000000.
- Byte lanes: s1 writes 0xAABBCCDD to addr 3 with be=0xF, then 0x11223344 with be=0x5 -> s2 read of addr 3 returns 0xAA22CC44.
- Latency: READ_LATENCY=2, s1 reads addrs 0,1,2 on consecutive cycles -> valid pulses at cycles +2,+3,+4 with data in order.
- Stall: reset_req=1 for 3 cycles between two reads -> waitrequest=1 on both ports, no lost or duplicated valid pulse, data order preserved.
- Collision: s1 writes 0x1 and s2 writes 0x2 to addr 5 in the same cycle -> collision pulses once; addr 5 reads 0x1.
- Boundaries: write to addr 16 is dropped and its read returns 0; reset at clear count 7 restarts the clear at 0 (busy lasts 16 more cycles).
